delay_align: RTL
================

Name: delay_align

Overview:
- Latency-compensating aligner for two parallel streams.
- Stream A is early and stream B is late. The block measures the skew between a marker pulse on A and the matching marker on B, counted in CE cycles.
- It then delays A by exactly that skew through a circular buffer, so both streams leave the block cycle-aligned.
- It sits downstream of fixed Delay_reg pipelines whose latency differs between the two paths.

Parameters:
SW, 8, data width of each stream (>=1)
MAXD, 64, circular buffer depth; largest measurable skew is MAXD-1 (power of 2, >=2)
AW, 6, pointer/delay width, equal to log2(MAXD)

Ports:
Ck  input  1  clock; all state changes on its rising edge
Rstn  input  1  reset; asynchronous, active-low
CE  input  1  clock enable; when low, all state holds
DIA  input  SW  early stream data
MKA  input  1  marker pulse on stream A
DIB  input  SW  late stream data
MKB  input  1  marker pulse on stream B
Start  input  1  one-cycle request to (re)measure the skew
DOA  output  SW  stream A delayed by Dly+1 CE cycles
DOB  output  SW  stream B delayed by 1 CE cycle
Dly  output  AW  currently applied skew
Lock  output  1  a valid skew is measured and applied
Err  output  1  the last measurement timed out

Behaviour:
- Reset (Rstn=0, async): state=IDLE, write pointer wp=0, cnt=0, Dly=0, Lock=0, Err=0, DOA=0, DOB=0. Buffer contents are not reset.
- All inputs are sampled only when CE=1. When CE=0, nothing changes: pointer, state, counters and outputs all hold.
- Data path (every CE cycle, in every state):
  - mem[wp] <= DIA; wp <= wp+1, wrapping modulo MAXD.
  - DOB <= DIB.
  - DOA <= DIA when Dly==0, else mem[wp-Dly], with AW-bit wrap arithmetic. The read uses the pre-write contents, so the entry read is the DIA sample from Dly CE cycles earlier.
  - Net effect: DOA(t) = DIA(t-1-Dly) and DOB(t) = DIB(t-1).
- FSM states: IDLE, ARM, MEAS, LOCK.
  - IDLE: Start -> ARM, clear Err.
  - ARM: Lock=0 while in this state; Dly keeps its old value.
    - MKA&MKB together -> Dly<=0, Lock<=1, go to LOCK.
    - MKA alone -> cnt<=1, go to MEAS.
    - MKB alone is ignored.
  - MEAS:
    - MKB -> Dly<=cnt, Lock<=1, go to LOCK.
    - Else if cnt==MAXD-1 -> Err<=1, go to IDLE; Dly is unchanged and Lock stays 0.
    - Else cnt<=cnt+1.
    - Further MKA pulses in MEAS are ignored.
  - LOCK: hold Dly; markers are ignored. Start -> ARM, with Lock<=0 in the same edge.
- Start has priority over markers in every state except IDLE. Start in ARM or MEAS restarts at ARM with cnt=0.
- Start in LOCK with MKA in the same cycle: go to ARM; MKA is not captured.
- Dly only ever changes on entering LOCK, so the applied delay steps once, in a single cycle.
- Err is sticky until the next Start.
- DOA content is defined only once the buffer has been filled past Dly entries since reset. Checkers qualify DOA with Lock.
- Reset mid-measurement aborts immediately to the reset values above.

Decomposition:
- Include file delay_defs.vh holds:
  - FSM state encodings (2-bit): IDLE=0, ARM=1, MEAS=2, LOCK=3.
  - clog2 helper macro used to check AW against MAXD.
- One sub-module, delay_ram: MAXD x SW simple dual-port memory with synchronous write and asynchronous read, write-enable tied to CE.
- The top level holds the pointer, FSM, counter and output registers.

Test Plan:
- Skew of 5: Start, then MKA at cycle 10, then MKB at cycle 15 with DIA=DIB=ramp -> Dly=5 and Lock=1 at cycle 16. From then on DOA==DOB every cycle, DOA(t)=DIA(t-6).
- Zero skew: MKA and MKB together in ARM -> Dly=0, Lock=1 next cycle, DOA(t)=DIA(t-1).
- Timeout: MAXD=8, MKA and no MKB -> Err=1 after 7 MEAS cycles, state IDLE, Lock=0, Dly keeps the previous value (e.g. 3). The next Start clears Err.
- CE gating: alternate CE=1/0 during a skew-4 measurement -> Dly=4 (CE cycles, not clocks). DOA/DOB hold on CE=0 cycles.
- Re-lock and wrap: locked at Dly=MAXD-1, run 3*MAXD cycles -> alignment held across pointer wrap. Then Start, MKA, and MKB 2 cycles later -> Lock drops for the measurement, Dly steps 63->2 in one cycle, and alignment is re-established.
- Async reset: assert Rstn low mid-MEAS, between clock edges -> all outputs 0 without waiting for a Ck edge. After release, the FSM is IDLE and Start is required before Lock can rise.

Source files
------------

// File: rtl/delay_align_pkg.sv
// Shared types and helpers for the two-stream skew aligner.
package delay_align_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2,
        ST_LOCK = 2'd3
    } state_t;

    // Ceiling log2, used to check the pointer width against the buffer depth.
    function automatic int unsigned clog2_u(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/delay_ram.sv
// MAXD x SW simple dual-port buffer: synchronous write, asynchronous read.
module delay_ram #(
    parameter int unsigned SW   = 8,
    parameter int unsigned MAXD = 64,
    parameter int unsigned AW   = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [SW-1:0] wd,
    input  logic [AW-1:0] ra,
    output logic [SW-1:0] rd_c
);

    logic [SW-1:0] mem [0:MAXD-1];

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
    end

    assign rd_c = mem[ra];

endmodule

// File: rtl/delay_align.sv
// Measures marker skew between an early stream A and a late stream B, then
// delays A through a circular buffer so both leave cycle-aligned.
module delay_align
    import delay_align_pkg::*;
#(
    parameter int unsigned SW   = 8,
    parameter int unsigned MAXD = 64,
    parameter int unsigned AW   = 6
) (
    input  logic          Ck,
    input  logic          Rstn,
    input  logic          CE,
    input  logic [SW-1:0] DIA,
    input  logic          MKA,
    input  logic [SW-1:0] DIB,
    input  logic          MKB,
    input  logic          Start,
    output logic [SW-1:0] DOA,
    output logic [SW-1:0] DOB,
    output logic [AW-1:0] Dly,
    output logic          Lock,
    output logic          Err
);

    localparam int unsigned CNT_MAX = MAXD - 1;

    if ((clog2_u(MAXD) != AW) || ((32'd1 << AW) != MAXD)) begin : g_bad_aw
        $error("delay_align: MAXD must be a power of 2 equal to 2**AW");
    end

    state_t        state_q;
    logic [AW-1:0] wp;
    logic [AW-1:0] cnt;
    logic [AW-1:0] rd_addr_c;
    logic [SW-1:0] rd_data_c;

    // Read happens before the write at wp lands, so this is DIA from Dly CE cycles ago.
    assign rd_addr_c = wp - Dly;

    delay_ram #(
        .SW   (SW),
        .MAXD (MAXD),
        .AW   (AW)
    ) u_ram (
        .clk  (Ck),
        .we   (CE),
        .wa   (wp),
        .wd   (DIA),
        .ra   (rd_addr_c),
        .rd_c (rd_data_c)
    );

    always_ff @(posedge Ck or negedge Rstn) begin
        if (!Rstn) begin
            state_q <= ST_IDLE;
            wp      <= '0;
            cnt     <= '0;
            Dly     <= '0;
            Lock    <= 1'b0;
            Err     <= 1'b0;
            DOA     <= '0;
            DOB     <= '0;
        end else if (CE) begin
            wp  <= wp + AW'(1);
            DOB <= DIB;
            DOA <= (Dly == '0) ? DIA : rd_data_c;

            // Start outranks markers; Dly only moves on entry to LOCK.
            unique case (state_q)
                ST_IDLE: begin
                    if (Start) begin
                        state_q <= ST_ARM;
                        cnt     <= '0;
                        Err     <= 1'b0;
                    end
                end
                ST_ARM: begin
                    if (Start) begin
                        cnt <= '0;
                        Err <= 1'b0;
                    end else if (MKA && MKB) begin
                        Dly     <= '0;
                        Lock    <= 1'b1;
                        state_q <= ST_LOCK;
                    end else if (MKA) begin
                        cnt     <= AW'(1);
                        state_q <= ST_MEAS;
                    end
                end
                ST_MEAS: begin
                    if (Start) begin
                        cnt     <= '0;
                        Err     <= 1'b0;
                        state_q <= ST_ARM;
                    end else if (MKB) begin
                        Dly     <= cnt;
                        Lock    <= 1'b1;
                        state_q <= ST_LOCK;
                    end else if (cnt == AW'(CNT_MAX)) begin
                        Err     <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt <= cnt + AW'(1);
                    end
                end
                ST_LOCK: begin
                    if (Start) begin
                        cnt     <= '0;
                        Err     <= 1'b0;
                        Lock    <= 1'b0;
                        state_q <= ST_ARM;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
